// File: rtl/hci_latency_stats_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : hci_latency_stats_accumulator
// Description : Per-master latency statistics (count, sum, min, max, sticky
//               flags) with saturating fixed-width counters and a registered
//               single-cycle read port.
// Revision    : 1.0 - initial release
// ============================================================================
module hci_latency_stats_accumulator #(
    parameter int N_MASTER = 4,
    parameter int LAT_W    = 16,
    parameter int CNT_W    = 32,
    parameter int SUM_W    = 48
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear_i,
    input  logic [N_MASTER-1:0]                  sample_valid_i,
    input  logic [N_MASTER-1:0][LAT_W-1:0]       sample_lat_i,
    input  logic                                 rd_req_i,
    input  logic [$clog2(N_MASTER)-1:0]          rd_master_i,
    output logic                                 rd_valid_o,
    output logic [CNT_W-1:0]                     rd_count_o,
    output logic [SUM_W-1:0]                     rd_sum_o,
    output logic [LAT_W-1:0]                     rd_min_o,
    output logic [LAT_W-1:0]                     rd_max_o,
    output logic [2:0]                           rd_flags_o
);

    // Per-master state exported from the generate loop for the read mux.
    logic [CNT_W-1:0] w_count [N_MASTER];
    logic [SUM_W-1:0] w_sum   [N_MASTER];
    logic [LAT_W-1:0] w_min   [N_MASTER];
    logic [LAT_W-1:0] w_max   [N_MASTER];
    logic [2:0]       w_flags [N_MASTER];

    for (genvar m = 0; m < N_MASTER; m++) begin : g_master
        logic [CNT_W-1:0] r_count;
        logic [SUM_W-1:0] r_sum;
        logic [LAT_W-1:0] r_min;
        logic [LAT_W-1:0] r_max;
        logic [2:0]       r_flags;   // {zero_lat_err, sum_sat, cnt_sat}

        logic [LAT_W-1:0] w_lat;
        logic             w_accept;
        logic             w_zero;
        logic [SUM_W:0]   w_sum_nxt;

        assign w_lat     = sample_lat_i[m];
        assign w_accept  = sample_valid_i[m] && (w_lat != '0) && !clear_i;
        assign w_zero    = sample_valid_i[m] && (w_lat == '0) && !clear_i;
        // One extra bit catches the carry out of the SUM_W-bit sum.
        assign w_sum_nxt = {1'b0, r_sum} + {{(SUM_W + 1 - LAT_W){1'b0}}, w_lat};

        // Accumulate accepted samples; clear wins over a same-cycle sample.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_count <= '0;
                r_sum   <= '0;
                r_min   <= '1;
                r_max   <= '0;
                r_flags <= '0;
            end else if (clear_i) begin
                r_count <= '0;
                r_sum   <= '0;
                r_min   <= '1;
                r_max   <= '0;
                r_flags <= '0;
            end else begin
                if (w_zero) begin
                    r_flags[2] <= 1'b1;
                end
                if (w_accept) begin
                    if (r_count == '1) begin
                        r_flags[0] <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (w_sum_nxt[SUM_W]) begin
                        r_sum      <= '1;
                        r_flags[1] <= 1'b1;
                    end else begin
                        r_sum <= w_sum_nxt[SUM_W-1:0];
                    end
                    if (w_lat < r_min) begin
                        r_min <= w_lat;
                    end
                    if (w_lat > r_max) begin
                        r_max <= w_lat;
                    end
                end
            end
        end

        assign w_count[m] = r_count;
        assign w_sum[m]   = r_sum;
        assign w_min[m]   = r_min;
        assign w_max[m]   = r_max;
        assign w_flags[m] = r_flags;
    end

    logic             w_rd_in_range;
    logic [CNT_W-1:0] w_rd_count;
    logic [SUM_W-1:0] w_rd_sum;
    logic [LAT_W-1:0] w_rd_min;
    logic [LAT_W-1:0] w_rd_max;
    logic [2:0]       w_rd_flags;

    assign w_rd_in_range = (32'(rd_master_i) < N_MASTER);

    // Select the addressed master's current (pre-update) state; out-of-range reads give zero.
    always_comb begin
        w_rd_count = '0;
        w_rd_sum   = '0;
        w_rd_min   = '0;
        w_rd_max   = '0;
        w_rd_flags = '0;
        if (w_rd_in_range) begin
            w_rd_count = w_count[rd_master_i];
            w_rd_sum   = w_sum[rd_master_i];
            w_rd_min   = w_min[rd_master_i];
            w_rd_max   = w_max[rd_master_i];
            w_rd_flags = w_flags[rd_master_i];
        end
    end

    logic             r_rd_valid;
    logic [CNT_W-1:0] r_rd_count;
    logic [SUM_W-1:0] r_rd_sum;
    logic [LAT_W-1:0] r_rd_min;
    logic [LAT_W-1:0] r_rd_max;
    logic [2:0]       r_rd_flags;

    // Register the read response; data holds between requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_count <= '0;
            r_rd_sum   <= '0;
            r_rd_min   <= '0;
            r_rd_max   <= '0;
            r_rd_flags <= '0;
        end else begin
            r_rd_valid <= rd_req_i;
            if (rd_req_i) begin
                r_rd_count <= w_rd_count;
                r_rd_sum   <= w_rd_sum;
                r_rd_min   <= w_rd_min;
                r_rd_max   <= w_rd_max;
                r_rd_flags <= w_rd_flags;
            end
        end
    end

    assign rd_valid_o = r_rd_valid;
    assign rd_count_o = r_rd_count;
    assign rd_sum_o   = r_rd_sum;
    assign rd_min_o   = r_rd_min;
    assign rd_max_o   = r_rd_max;
    assign rd_flags_o = r_rd_flags;

endmodule
`default_nettype wire

// File: tb/tb_hci_latency_stats_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_hci_latency_stats_accumulator
// Description : Directed, table-driven bench for the latency statistics
//               accumulator, plus a narrow-width instance for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hci_latency_stats_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic             clear_i;
    logic [3:0]       sample_valid_i;
    logic [3:0][15:0] sample_lat_i;
    logic             rd_req_i;
    logic [1:0]       rd_master_i;
    logic             rd_valid_o;
    logic [31:0]      rd_count_o;
    logic [47:0]      rd_sum_o;
    logic [15:0]      rd_min_o;
    logic [15:0]      rd_max_o;
    logic [2:0]       rd_flags_o;

    hci_latency_stats_accumulator dut (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clear_i),
        .sample_valid_i (sample_valid_i),
        .sample_lat_i   (sample_lat_i),
        .rd_req_i       (rd_req_i),
        .rd_master_i    (rd_master_i),
        .rd_valid_o     (rd_valid_o),
        .rd_count_o     (rd_count_o),
        .rd_sum_o       (rd_sum_o),
        .rd_min_o       (rd_min_o),
        .rd_max_o       (rd_max_o),
        .rd_flags_o     (rd_flags_o)
    );

    // Narrow instance: CNT_W=3, SUM_W=17 for saturation corners
    logic             s_clear;
    logic [3:0]       s_valid;
    logic [3:0][15:0] s_lat;
    logic             s_rd_req;
    logic [1:0]       s_rd_master;
    logic             s_rd_valid;
    logic [2:0]       s_rd_count;
    logic [16:0]      s_rd_sum;
    logic [15:0]      s_rd_min;
    logic [15:0]      s_rd_max;
    logic [2:0]       s_rd_flags;

    hci_latency_stats_accumulator #(.N_MASTER(4), .LAT_W(16), .CNT_W(3), .SUM_W(17)) dut_s (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (s_clear),
        .sample_valid_i (s_valid),
        .sample_lat_i   (s_lat),
        .rd_req_i       (s_rd_req),
        .rd_master_i    (s_rd_master),
        .rd_valid_o     (s_rd_valid),
        .rd_count_o     (s_rd_count),
        .rd_sum_o       (s_rd_sum),
        .rd_min_o       (s_rd_min),
        .rd_max_o       (s_rd_max),
        .rd_flags_o     (s_rd_flags)
    );

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_main(input string nm, input logic [31:0] c, input logic [47:0] s,
                            input logic [15:0] mn, input logic [15:0] mx, input logic [2:0] f);
        cmp({nm, ".count"}, 64'(rd_count_o), 64'(c));
        cmp({nm, ".sum"},   64'(rd_sum_o),   64'(s));
        cmp({nm, ".min"},   64'(rd_min_o),   64'(mn));
        cmp({nm, ".max"},   64'(rd_max_o),   64'(mx));
        cmp({nm, ".flags"}, 64'(rd_flags_o), 64'(f));
    endtask

    task automatic chk_s(input string nm, input logic [2:0] c, input logic [16:0] s,
                         input logic [15:0] mn, input logic [15:0] mx, input logic [2:0] f);
        cmp({nm, ".valid"}, 64'(s_rd_valid), 64'd1);
        cmp({nm, ".count"}, 64'(s_rd_count), 64'(c));
        cmp({nm, ".sum"},   64'(s_rd_sum),   64'(s));
        cmp({nm, ".min"},   64'(s_rd_min),   64'(mn));
        cmp({nm, ".max"},   64'(s_rd_max),   64'(mx));
        cmp({nm, ".flags"}, 64'(s_rd_flags), 64'(f));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One record = inputs for one cycle and the read response seen after that edge.
    typedef struct {
        logic [3:0]       v;
        logic [3:0][15:0] lat;
        logic             clr;
        logic             rd;
        logic [1:0]       rm;
        logic             chk;
        logic [31:0]      c;
        logic [47:0]      s;
        logic [15:0]      mn;
        logic [15:0]      mx;
        logic [2:0]       f;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [15:0] l3, input logic [15:0] l2,
                                input logic [15:0] l1, input logic [15:0] l0, input logic clr,
                                input logic rd, input logic [1:0] rm, input logic chk,
                                input logic [31:0] c, input logic [47:0] s, input logic [15:0] mn,
                                input logic [15:0] mx, input logic [2:0] f);
        vec_t r;
        r.v = v; r.lat = {l3, l2, l1, l0}; r.clr = clr; r.rd = rd; r.rm = rm; r.chk = chk;
        r.c = c; r.s = s; r.mn = mn; r.mx = mx; r.f = f;
        return r;
    endfunction

    vec_t tbl [17];

    initial begin
        //          v       l3      l2      l1  l0  clr rd rm chk  count sum    min      max      flags
        tbl[0]  = mk(4'b0001, 0,      0,      0,  3,  0,  0, 0, 0,  0,    0,     0,       0,       3'b000);
        tbl[1]  = mk(4'b0001, 0,      0,      0,  5,  0,  0, 0, 0,  0,    0,     0,       0,       3'b000);
        tbl[2]  = mk(4'b0001, 0,      0,      0,  2,  0,  0, 0, 0,  0,    0,     0,       0,       3'b000);
        tbl[3]  = mk(4'b0000, 0,      0,      0,  0,  0,  1, 0, 1,  3,    10,    2,       5,       3'b000);
        // clear + sample on m1 + read m0 -> pre-clear m0 values
        tbl[4]  = mk(4'b0010, 0,      0,      7,  0,  1,  1, 0, 1,  3,    10,    2,       5,       3'b000);
        tbl[5]  = mk(4'b0000, 0,      0,      0,  0,  0,  1, 1, 1,  0,    0,     16'hFFFF, 0,      3'b000);
        tbl[6]  = mk(4'b0100, 0,      0,      0,  0,  0,  0, 0, 0,  0,    0,     0,       0,       3'b000);
        tbl[7]  = mk(4'b0000, 0,      0,      0,  0,  0,  1, 2, 1,  0,    0,     16'hFFFF, 0,      3'b100);
        tbl[8]  = mk(4'b0100, 0,      4,      0,  0,  0,  0, 0, 0,  0,    0,     0,       0,       3'b000);
        tbl[9]  = mk(4'b0000, 0,      0,      0,  0,  0,  1, 2, 1,  1,    4,     4,       4,       3'b100);
        // read m3 in the same cycle as its sample -> prior values
        tbl[10] = mk(4'b1000, 9,      0,      0,  0,  0,  1, 3, 1,  0,    0,     16'hFFFF, 0,      3'b000);
        tbl[11] = mk(4'b0000, 0,      0,      0,  0,  0,  1, 3, 1,  1,    9,     9,       9,       3'b000);
        tbl[12] = mk(4'b1111, 1,      30,     20, 10, 0,  0, 0, 0,  0,    0,     0,       0,       3'b000);
        tbl[13] = mk(4'b0100, 0,      16'hFFFF, 0, 0, 0,  1, 2, 1,  2,    34,    4,       30,      3'b100);
        tbl[14] = mk(4'b0000, 0,      0,      0,  0,  0,  1, 3, 1,  2,    10,    1,       9,       3'b000);
        // no request: data must hold previous response
        tbl[15] = mk(4'b0000, 0,      0,      0,  0,  0,  0, 0, 1,  2,    10,    1,       9,       3'b000);
        tbl[16] = mk(4'b0000, 0,      0,      0,  0,  0,  1, 2, 1,  3,    65569, 4,       16'hFFFF, 3'b100);
    end

    initial begin
        clear_i = 0; sample_valid_i = '0; sample_lat_i = '0; rd_req_i = 0; rd_master_i = '0;
        s_clear = 0; s_valid = '0; s_lat = '0; s_rd_req = 0; s_rd_master = '0;
        rst = 1'b1;
        repeat (3) step();
        cmp("reset.valid", 64'(rd_valid_o), 64'd0);
        chk_main("reset", 0, 0, 0, 0, 3'b000);
        rst = 1'b0;

        // Table-driven sequence
        for (int i = 0; i < 17; i++) begin
            sample_valid_i = tbl[i].v;
            sample_lat_i   = tbl[i].lat;
            clear_i        = tbl[i].clr;
            rd_req_i       = tbl[i].rd;
            rd_master_i    = tbl[i].rm;
            step();
            cmp($sformatf("vec%0d.valid", i), 64'(rd_valid_o), 64'(tbl[i].rd));
            if (tbl[i].chk)
                chk_main($sformatf("vec%0d", i), tbl[i].c, tbl[i].s, tbl[i].mn, tbl[i].mx, tbl[i].f);
        end
        sample_valid_i = '0; sample_lat_i = '0; clear_i = 0; rd_req_i = 0;

        // All masters every cycle for 100 cycles, master m with latency m+1
        clear_i = 1; step(); clear_i = 0;
        sample_valid_i = 4'b1111;
        sample_lat_i   = {16'd4, 16'd3, 16'd2, 16'd1};
        repeat (100) step();
        sample_valid_i = '0;
        // Back-to-back reads of all masters
        for (int m = 0; m < 4; m++) begin
            rd_req_i = 1; rd_master_i = 2'(m);
            step();
            cmp($sformatf("bulk%0d.valid", m), 64'(rd_valid_o), 64'd1);
            chk_main($sformatf("bulk%0d", m), 100, 48'(100 * (m + 1)), 16'(m + 1), 16'(m + 1), 3'b000);
        end
        rd_req_i = 0;
        step();
        cmp("bulk.valid_drop", 64'(rd_valid_o), 64'd0);

        // Saturation on narrow instance
        s_valid = 4'b0001; s_lat = {48'd0, 16'hFFFF};
        repeat (6) step();
        s_valid = '0; s_rd_req = 1; s_rd_master = 0;
        step();
        chk_s("sat6", 3'd6, 17'h1FFFF, 16'hFFFF, 16'hFFFF, 3'b010);
        s_rd_req = 0; s_valid = 4'b0001;
        step();
        s_valid = '0; s_rd_req = 1;
        step();
        chk_s("sat7", 3'd7, 17'h1FFFF, 16'hFFFF, 16'hFFFF, 3'b010);
        s_rd_req = 0; s_valid = 4'b0001; s_lat = {48'd0, 16'h0002};
        step();
        s_valid = '0; s_rd_req = 1;
        step();
        chk_s("cntsat", 3'd7, 17'h1FFFF, 16'h0002, 16'hFFFF, 3'b011);
        s_rd_req = 0;

        // Reset while a read is pending, then while its valid is high
        rd_req_i = 1; rd_master_i = 3;
        #2 rst = 1'b1;
        step();
        cmp("rst_pending.valid", 64'(rd_valid_o), 64'd0);
        rst = 1'b0;
        step();
        cmp("rst_pending.valid2", 64'(rd_valid_o), 64'd1);
        chk_main("post_rst", 0, 0, 16'hFFFF, 0, 3'b000);
        rst = 1'b1;
        #1;
        cmp("rst_async.valid", 64'(rd_valid_o), 64'd0);
        cmp("rst_async.min", 64'(rd_min_o), 64'd0);
        rd_req_i = 0;
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
